// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_operand_stage_if : writeback, request and operand buses of the ALU
//                        operand-fetch stage. Rev 1.0
// ---------------------------------------------------------------------------
interface alu_operand_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wb_en;
  logic [ADDR_W-1:0] wb_num;
  logic [DATA_W-1:0] wb_data;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rn;
  logic [ADDR_W-1:0] req_rm;
  logic [1:0]        req_shift;
  logic              req_asel;
  logic              req_bsel;
  logic [4:0]        req_imm5;
  logic [1:0]        req_aluop;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] Ain;
  logic [DATA_W-1:0] Bin;
  logic [1:0]        ALUop;

  modport master (
    output wb_en, wb_num, wb_data,
    output req_valid, req_rn, req_rm, req_shift, req_asel, req_bsel, req_imm5, req_aluop,
    output op_ready,
    input  req_ready, op_valid, Ain, Bin, ALUop
  );

  modport slave (
    input  wb_en, wb_num, wb_data,
    input  req_valid, req_rn, req_rm, req_shift, req_asel, req_bsel, req_imm5, req_aluop,
    input  op_ready,
    output req_ready, op_valid, Ain, Bin, ALUop
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_operand_stage : 8x16 register file plus two-cycle operand fetch
//                     feeding the ALU over a valid/ready handshake. Rev 1.0
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_operand_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] rn_q, rn_d;
  logic [ADDR_W-1:0] rm_q, rm_d;
  logic [1:0]        shift_q, shift_d;
  logic              asel_q, asel_d;
  logic              bsel_q, bsel_d;
  logic [4:0]        imm5_q, imm5_d;
  logic [1:0]        aluop_q, aluop_d;

  logic [ADDR_W-1:0] rd_num;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rd_shifted;

  // A same-cycle writeback to the source register wins over the stored value.
  always_comb begin
    rd_num  = (state_q == READ_A) ? rn_q : rm_q;
    rd_data = (bus.wb_en && (bus.wb_num == rd_num)) ? bus.wb_data : rf_q[rd_num];
    case (shift_q)
      2'b01:   rd_shifted = {rd_data[DATA_W-2:0], 1'b0};
      2'b10:   rd_shifted = {1'b0, rd_data[DATA_W-1:1]};
      2'b11:   rd_shifted = {rd_data[DATA_W-1], rd_data[DATA_W-1:1]};
      default: rd_shifted = rd_data;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    if (bus.wb_en) begin
      rf_d[bus.wb_num] = bus.wb_data;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    shift_d = shift_q;
    asel_d  = asel_q;
    bsel_d  = bsel_q;
    imm5_d  = imm5_q;
    aluop_d = aluop_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rn_d    = bus.req_rn;
          rm_d    = bus.req_rm;
          shift_d = bus.req_shift;
          asel_d  = bus.req_asel;
          bsel_d  = bus.req_bsel;
          imm5_d  = bus.req_imm5;
          aluop_d = bus.req_aluop;
          state_d = READ_A;
        end
      end
      READ_A: begin
        a_d     = rd_data;
        state_d = READ_B;
      end
      READ_B: begin
        b_d     = rd_shifted;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.op_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      a_q     <= '0;
      b_q     <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm5_q  <= '0;
      aluop_q <= '0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      shift_q <= shift_d;
      asel_q  <= asel_d;
      bsel_q  <= bsel_d;
      imm5_q  <= imm5_d;
      aluop_q <= aluop_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.op_valid  = (state_q == ISSUE);
  assign bus.Ain       = asel_q ? '0 : a_q;
  assign bus.Bin       = bsel_q ? {{(DATA_W-5){imm5_q[4]}}, imm5_q} : b_q;
  assign bus.ALUop     = aluop_q;

endmodule
`default_nettype wire
